// File: rtl/bip_debug_ctrl.sv
// bip_debug_ctrl
// Command sequencer between the UART and the BIP core. It decodes RUN/STEP
// command words, drives the BIP clear and clock-enable, and then reports
// accumulator, PC and cycle count as three words into the UART TX FIFO.
module bip_debug_ctrl #(
    parameter int              DBIT     = 16,
    parameter int              PC_W     = 11,
    parameter logic [DBIT-1:0] CMD_RUN  = 16'h0052,
    parameter logic [DBIT-1:0] CMD_STEP = 16'h0053
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DBIT-1:0] rx_data,
    input  logic            rx_done,
    input  logic            tx_full,
    input  logic            bip_halt,
    input  logic [DBIT-1:0] bip_acc,
    input  logic [PC_W-1:0] bip_pc,
    output logic            bip_clear,
    output logic            bip_en,
    output logic            wr_uart,
    output logic [DBIT-1:0] acc_uart,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_STEP,
        S_SNAP,
        S_SEND,
        S_FIN
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [DBIT-1:0] r_cycle_cnt;
    logic [1:0]      r_word_idx;
    logic [DBIT-1:0] r_snap0;
    logic [DBIT-1:0] r_snap1;
    logic [DBIT-1:0] r_snap2;

    // State register; reset drops straight back to IDLE, aborting any run or report
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the control strobes, all derived from the current state
    always_comb begin
        w_next    = r_state;
        bip_clear = 1'b0;
        bip_en    = 1'b0;
        wr_uart   = 1'b0;
        done      = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (rx_done) begin
                    if (rx_data == CMD_RUN) begin
                        w_next = S_CLEAR;
                    end else if (rx_data == CMD_STEP) begin
                        w_next = S_STEP;
                    end
                end
            end
            S_CLEAR: begin
                bip_clear = 1'b1;
                w_next    = S_RUN;
            end
            S_RUN: begin
                bip_en = ~bip_halt;
                if (bip_halt) begin
                    w_next = S_SNAP;
                end
            end
            S_STEP: begin
                bip_en = ~bip_halt;
                w_next = S_SNAP;
            end
            S_SNAP: begin
                w_next = S_SEND;
            end
            S_SEND: begin
                wr_uart = ~tx_full;
                if (!tx_full && (r_word_idx == 2'd2)) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Report word mux: only drives data while words are being sent, zero otherwise
    always_comb begin
        acc_uart = '0;
        if (r_state == S_SEND) begin
            case (r_word_idx)
                2'd0:    acc_uart = r_snap0;
                2'd1:    acc_uart = r_snap1;
                default: acc_uart = r_snap2;
            endcase
        end
    end

    // Cycle counter, snapshot latches and report index; the counter saturates rather than wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt <= '0;
            r_word_idx  <= '0;
            r_snap0     <= '0;
            r_snap1     <= '0;
            r_snap2     <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cycle_cnt <= '0;
                end
                S_RUN, S_STEP: begin
                    if (bip_en && (r_cycle_cnt != '1)) begin
                        r_cycle_cnt <= r_cycle_cnt + DBIT'(1);
                    end
                end
                S_SNAP: begin
                    r_snap0    <= bip_acc;
                    r_snap1    <= DBIT'(bip_pc);
                    r_snap2    <= r_cycle_cnt;
                    r_word_idx <= '0;
                end
                S_SEND: begin
                    if (wr_uart) begin
                        r_word_idx <= r_word_idx + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip_debug_ctrl.sv
// tb_bip_debug_ctrl
// Drives RUN/STEP commands with randomized data, halt timing and TX backpressure,
// and checks every report against a transaction-level model of the cycle count.
module tb_bip_debug_ctrl;

    localparam int          DBIT     = 16;
    localparam int          PC_W     = 11;
    localparam logic [15:0] CMD_RUN  = 16'h0052;
    localparam logic [15:0] CMD_STEP = 16'h0053;
    localparam int          CNT_MAX  = 65535;

    logic            clk;
    logic            reset;
    logic [DBIT-1:0] rx_data;
    logic            rx_done;
    logic            tx_full;
    logic            bip_halt;
    logic [DBIT-1:0] bip_acc;
    logic [PC_W-1:0] bip_pc;
    logic            bip_clear;
    logic            bip_en;
    logic            wr_uart;
    logic [DBIT-1:0] acc_uart;
    logic            busy;
    logic            done;

    int compared;
    int mismatched;

    int modelCnt;
    logic [15:0] expQ[$];
    logic [15:0] wrLog[$];
    int enCount;
    int clearCount;
    int doneCount;
    int wrCount;

    bip_debug_ctrl #(
        .DBIT    (DBIT),
        .PC_W    (PC_W),
        .CMD_RUN (CMD_RUN),
        .CMD_STEP(CMD_STEP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .tx_full  (tx_full),
        .bip_halt (bip_halt),
        .bip_acc  (bip_acc),
        .bip_pc   (bip_pc),
        .bip_clear(bip_clear),
        .bip_en   (bip_en),
        .wr_uart  (wr_uart),
        .acc_uart (acc_uart),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearMonitor();
        enCount    = 0;
        clearCount = 0;
        doneCount  = 0;
        wrCount    = 0;
        wrLog.delete();
    endtask

    // Observes the outputs each falling edge: invariants plus report words against the model queue
    always @(negedge clk) begin
        if (reset) begin
            if (bip_en) begin
                enCount++;
                checkOutput("en_while_halted", 32'(bip_halt), 32'd0);
                checkOutput("en_exclusive", 32'({bip_clear, wr_uart, done}), 32'd0);
            end
            if (bip_clear) clearCount++;
            if (done) doneCount++;
            if (!busy) begin
                checkOutput("idle_outputs", 32'({bip_en, bip_clear, wr_uart, done, acc_uart}), 32'd0);
            end
            if (wr_uart) begin
                wrCount++;
                wrLog.push_back(acc_uart);
                checkOutput("write_while_full", 32'(tx_full), 32'd0);
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_write: got %h, expected no write", acc_uart);
                end else begin
                    checkOutput("report_word", 32'(acc_uart), 32'(expQ.pop_front()));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] word);
        rx_data = word;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 16'($urandom);
    endtask

    // Lets the report drain under optional backpressure and command injection
    task automatic waitReport(input bit bp, input bit inj);
        int k;
        int bpLeft;
        bit injected;
        k = 0;
        bpLeft = 4;
        injected = 1'b0;
        while (!done && k < 300) begin
            if (bp && wrCount >= 1 && bpLeft > 0) begin
                tx_full = 1'b1;
                bpLeft--;
            end else begin
                tx_full = ($urandom_range(0, 3) == 0);
            end
            if (inj && wrCount >= 1 && !injected) begin
                rx_data  = CMD_RUN;
                rx_done  = 1'b1;
                injected = 1'b1;
            end else begin
                rx_done = 1'b0;
            end
            tick();
            k++;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL report_timeout: got no done after %0d cycles, expected done", k);
        end
        if (inj) begin
            rx_data = CMD_STEP;
            rx_done = 1'b1;
        end
        tick();
        rx_done = 1'b0;
        tx_full = 1'b0;
    endtask

    task automatic postChecks(input int expEn, input int expClear);
        checkOutput("en_cycles", 32'(enCount), 32'(expEn));
        checkOutput("clear_pulses", 32'(clearCount), 32'(expClear));
        checkOutput("done_pulses", 32'(doneCount), 32'd1);
        checkOutput("write_count", 32'(wrCount), 32'd3);
        checkOutput("queue_left", 32'(expQ.size()), 32'd0);
        checkOutput("idle_after_fin", 32'(busy), 32'd0);
        tick();
        checkOutput("still_idle", 32'(busy), 32'd0);
    endtask

    task automatic doRun(input int n, input logic [15:0] accV, input logic [10:0] pcV,
                         input bit bp, input bit inj);
        bip_halt = 1'b0;
        bip_acc  = accV;
        bip_pc   = pcV;
        clearMonitor();
        modelCnt = (n > CNT_MAX) ? CNT_MAX : n;
        expQ.push_back(accV);
        expQ.push_back({5'b0, pcV});
        expQ.push_back(16'(modelCnt));
        applyStimulus(CMD_RUN);
        checkOutput("clear_latency", 32'(bip_clear), 32'd1);
        if (n == 0) bip_halt = 1'b1;
        tick();
        checkOutput("clear_one_cycle", 32'(bip_clear), 32'd0);
        repeat (n) tick();
        bip_halt = 1'b1;
        waitReport(bp, inj);
        postChecks(n, 1);
    endtask

    task automatic doStep(input bit haltV, input logic [15:0] accV, input logic [10:0] pcV,
                          input bit inj);
        bip_halt = haltV;
        bip_acc  = accV;
        bip_pc   = pcV;
        clearMonitor();
        if (!haltV && modelCnt < CNT_MAX) modelCnt++;
        expQ.push_back(accV);
        expQ.push_back({5'b0, pcV});
        expQ.push_back(16'(modelCnt));
        applyStimulus(CMD_STEP);
        checkOutput("step_enable", 32'(bip_en), 32'(!haltV));
        waitReport(1'b0, inj);
        postChecks(haltV ? 0 : 1, 0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        modelCnt   = 0;
        clearMonitor();
        reset    = 1'b0;
        rx_data  = '0;
        rx_done  = 1'b0;
        tx_full  = 1'b0;
        bip_halt = 1'b0;
        bip_acc  = '0;
        bip_pc   = '0;

        repeat (3) tick();
        checkOutput("reset_outputs", 32'({bip_clear, bip_en, wr_uart, busy, done, acc_uart}), 32'd0);
        reset = 1'b1;
        tick();
        $display("[TB] reset released");

        applyStimulus(16'h0041);
        checkOutput("ignored_word_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("ignored_word_no_run", 32'(enCount + clearCount), 32'd0);

        doRun(25, 16'h00A5, 11'h019, 1'b0, 1'b0);
        checkOutput("run_word_acc", 32'(wrLog[0]), 32'h00A5);
        checkOutput("run_word_pc", 32'(wrLog[1]), 32'h0019);
        checkOutput("run_word_count", 32'(wrLog[2]), 32'd25);

        doRun(25, 16'h00A5, 11'h019, 1'b1, 1'b0);
        checkOutput("bp_word_acc", 32'(wrLog[0]), 32'h00A5);
        checkOutput("bp_word_pc", 32'(wrLog[1]), 32'h0019);
        checkOutput("bp_word_count", 32'(wrLog[2]), 32'd25);

        bip_halt = 1'b0;
        clearMonitor();
        applyStimulus(CMD_RUN);
        repeat (6) tick();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("reset_midrun_en", 32'(bip_en), 32'd0);
        checkOutput("reset_midrun_busy", 32'(busy), 32'd0);
        checkOutput("reset_midrun_wr", 32'(wr_uart), 32'd0);
        #2;
        reset = 1'b1;
        modelCnt = 0;
        expQ.delete();
        tick();

        doStep(1'b0, 16'h1234, 11'h7FF, 1'b0);
        checkOutput("step1_count", 32'(wrLog[2]), 32'd1);
        doStep(1'b0, 16'h0F0F, 11'h002, 1'b0);
        checkOutput("step2_count", 32'(wrLog[2]), 32'd2);
        doStep(1'b1, 16'hBEEF, 11'h100, 1'b0);
        checkOutput("step_halted_count", 32'(wrLog[2]), 32'd2);

        doRun(7, 16'h5A5A, 11'h3C3, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                doRun(int'($urandom_range(0, 40)), 16'($urandom), 11'($urandom),
                      1'($urandom), 1'($urandom));
            end else begin
                doStep(($urandom_range(0, 3) == 0), 16'($urandom), 11'($urandom), 1'($urandom));
            end
        end

        doRun(65540, 16'hCAFE, 11'h555, 1'b0, 1'b0);
        checkOutput("sat_count", 32'(wrLog[2]), 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bip_debug_ctrl.md
Name: bip_debug_ctrl

Overview:
- Command sequencer between the UART and the BIP processor core.
- Decodes 16-bit command words from the UART receiver and runs the BIP free-running or single-step.
- On halt or step completion, snapshots accumulator, PC and cycle count and pushes them as three words into the UART transmit FIFO.
- Sits beside the UART top level: consumes receiver data/done tick, drives wr_uart/acc_uart into the TX FIFO.

Parameters:
- DBIT, 16, width of UART data words, accumulator and cycle counter.
- PC_W, 11, BIP program-counter width (PC_W <= DBIT).
- CMD_RUN, 16'h0052, command word: clear BIP and run to halt.
- CMD_STEP, 16'h0053, command word: execute one BIP cycle, then report.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  DBIT  received word; valid only when rx_done is high.
- rx_done  in  1  one-cycle receiver done tick.
- tx_full  in  1  TX FIFO full flag.
- bip_halt  in  1  BIP has executed HLT (level).
- bip_acc  in  DBIT  BIP accumulator.
- bip_pc  in  PC_W  BIP program counter.
- bip_clear  out  1  one-cycle synchronous clear to the BIP.
- bip_en  out  1  BIP clock enable.
- wr_uart  out  1  TX FIFO write strobe.
- acc_uart  out  DBIT  TX FIFO write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last report word is written.

Behaviour:
- States: IDLE, CLEAR, RUN, STEP, SNAP, SEND, FIN.
  - State register is async-reset to IDLE.
  - All outputs are decoded from state and registers.
- Reset (reset=0), immediate at any point including mid-RUN or mid-SEND:
  - State goes to IDLE.
  - cycle_cnt=0, word_idx=0, snapshot registers=0.
  - Outputs bip_clear=0, bip_en=0, wr_uart=0, acc_uart=0, busy=0, done=0.
- IDLE:
  - rx_done=1 with rx_data==CMD_RUN -> CLEAR.
  - rx_done=1 with rx_data==CMD_STEP -> STEP.
  - Any other word is ignored; stay in IDLE.
- Commands in every non-IDLE state are dropped and never queued.
- CLEAR (1 cycle):
  - bip_clear=1.
  - cycle_cnt<=0.
  - bip_halt is ignored in this state.
  - Next state RUN.
- RUN:
  - bip_en = ~bip_halt (combinational).
  - Each cycle with bip_en=1: cycle_cnt increments, saturating at 2^DBIT-1 (no wrap).
  - bip_halt=1 -> SNAP. Check is made from the first RUN cycle.
- STEP (1 cycle):
  - bip_en = ~bip_halt.
  - cycle_cnt increments if bip_en=1.
  - STEP does not clear the BIP or the counter, so the count accumulates across steps.
  - Next state SNAP.
  - STEP while halted gives a report with unchanged values.
- SNAP (1 cycle, settle):
  - bip_en=0.
  - Latches snap0=bip_acc, snap1={zero-ext bip_pc}, snap2=cycle_cnt.
  - word_idx<=0.
  - Next state SEND.
- SEND:
  - wr_uart = ~tx_full (combinational).
  - acc_uart = snap[word_idx] while in SEND, else 0.
  - A word transfers on each edge with wr_uart=1, and word_idx increments.
  - tx_full=1 stalls with no write and holds the index; there is no timeout.
  - Transfer of word_idx==2 -> FIN.
  - Order is fixed: ACC, PC, COUNT.
- FIN (1 cycle):
  - done=1.
  - Next state IDLE.
  - A command arriving in FIN is dropped.
- Latency:
  - RUN command tick -> bip_clear is high in the next cycle.
  - Halt seen -> first wr_uart no earlier than 2 cycles later.
- bip_en is never high outside RUN/STEP; bip_clear is never high outside CLEAR.

Test Plan:
- Reset mid-RUN:
  - Stimulus: assert reset=0 asynchronously between edges.
  - Required: bip_en, busy, wr_uart drop immediately; after release, IDLE with cycle_cnt=0.
- Run to halt:
  - Stimulus: rx_data=16'h0052 with rx_done; bip_halt rises after 25 enabled cycles, acc=16'h00A5, pc=11'h019.
  - Required: 1-cycle bip_clear, then 25 bip_en cycles, then writes 16'h00A5, 16'h0019, 16'd25, then a done pulse.
- Backpressure:
  - Stimulus: same run as above, with tx_full=1 for 4 cycles after the first write.
  - Required: no writes while tx_full=1, order and values preserved, exactly 3 writes.
- Step accumulation:
  - Stimulus: two CMD_STEP commands, no halt.
  - Required: each gives exactly 1 bip_en cycle and 3 words; COUNT words are 1 then 2; bip_clear never asserted.
- Ignored commands:
  - Stimulus: rx_data=16'h0041 in IDLE; CMD_RUN during SEND.
  - Required: no state change, no extra run, busy unaffected.
- Saturation:
  - Stimulus: run with halt never asserted for 65540 cycles, then halt.
  - Required: COUNT word = 16'hFFFF.
